// File: rtl/fixed_point_multiplier_if.sv
// Operand/result handshake bundle for the serial fixed-point multiplier.
interface fixed_point_multiplier_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] o_result;
  logic             overflow_flag;

  modport slave (
    input  in_valid, multiplicand, multiplier, out_ready,
    output in_ready, out_valid, o_result, overflow_flag
  );

  modport master (
    output in_valid, multiplicand, multiplier, out_ready,
    input  in_ready, out_valid, o_result, overflow_flag
  );
endinterface

// File: rtl/fixed_point_multiplier.sv
// Signed fixed-point multiplier: sign-magnitude radix-2 shift-add over WIDTH cycles,
// followed by optional round-half-up and saturate/wrap scaling back to WIDTH bits.
module fixed_point_multiplier #(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter int ROUND    = 1,
  parameter int SATURATE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  fixed_point_multiplier_if.slave  bus
);

  localparam int PW  = 2 * WIDTH + 2;
  localparam int CW  = 6;
  localparam int RSH = (FRAC > 0) ? FRAC - 1 : 0;

  localparam logic [CW-1:0]          LAST_C = CW'(WIDTH);
  localparam logic [CW-1:0]          ONE_C  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]       ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic signed [PW-1:0]   RND    = (ROUND != 0 && FRAC > 0) ? (PW'(1'b1) << RSH) : PW'(1'b0);
  localparam logic signed [PW-1:0]   MAXV   = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0]   MINV   = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]       MAX_W  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]       MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nx_s;
  logic                 accept_s;
  logic [2*WIDTH-1:0]   mcand_sh_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]     mplier_r;
  logic                 neg_r;
  logic [CW-1:0]        cnt_r;
  logic [WIDTH-1:0]     result_r;
  logic                 ovf_r;

  // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1) exactly.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + ONE_W) : v;
  endfunction

  // Apply sign, rounding and the FRAC shift; return {overflow, clamped or wrapped result}.
  function automatic logic [WIDTH:0] scale(input logic [2*WIDTH-1:0] m, input logic n);
    logic signed [PW-1:0] mag_v;
    logic signed [PW-1:0] p_v;
    logic signed [PW-1:0] r_v;
    logic                 ovf_v;
    logic [WIDTH-1:0]     res_v;
    mag_v = {2'b00, m};
    p_v   = n ? -mag_v : mag_v;
    r_v   = (p_v + RND) >>> FRAC;
    ovf_v = (r_v > MAXV) || (r_v < MINV);
    if (ovf_v && (SATURATE != 0)) begin
      res_v = r_v[PW-1] ? MIN_W : MAX_W;
    end else begin
      res_v = r_v[WIDTH-1:0];
    end
    return {ovf_v, res_v};
  endfunction

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode and operand-accept strobe.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          accept_s   = 1'b1;
          state_nx_s = BUSY;
        end else begin
          state_nx_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == LAST_C) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = BUSY;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Operand capture, shift-add steps and final scaling into the result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_sh_r <= '0;
      acc_r      <= '0;
      mplier_r   <= '0;
      neg_r      <= 1'b0;
      cnt_r      <= '0;
      result_r   <= '0;
      ovf_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            mcand_sh_r <= {{WIDTH{1'b0}}, magnitude(bus.multiplicand)};
            mplier_r   <= magnitude(bus.multiplier);
            neg_r      <= bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1];
            acc_r      <= '0;
            cnt_r      <= '0;
          end
        end
        BUSY: begin
          // cnt_r == WIDTH is the extra cycle that scales the finished magnitude.
          if (cnt_r == LAST_C) begin
            {ovf_r, result_r} <= scale(acc_r, neg_r);
          end else begin
            if (mplier_r[0]) begin
              acc_r <= acc_r + mcand_sh_r;
            end
            mcand_sh_r <= mcand_sh_r << 1;
            mplier_r   <= mplier_r >> 1;
            cnt_r      <= cnt_r + ONE_C;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready      = (state_r == IDLE);
  assign bus.out_valid     = (state_r == DONE);
  assign bus.o_result      = result_r;
  assign bus.overflow_flag = ovf_r;

endmodule

// File: tb/tb_fixed_point_multiplier.sv
// Directed bench: three multiplier variants (round+sat, truncate+sat, round+wrap) share one stimulus.
module tb_fixed_point_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] mcand;
  logic [15:0] mplier;
  int          total = 0;
  int          bad   = 0;

  fixed_point_multiplier_if #(.WIDTH(16)) bus_def ();
  fixed_point_multiplier_if #(.WIDTH(16)) bus_trn ();
  fixed_point_multiplier_if #(.WIDTH(16)) bus_wrp ();

  assign bus_def.in_valid = in_valid;  assign bus_def.out_ready = out_ready;
  assign bus_def.multiplicand = mcand; assign bus_def.multiplier = mplier;
  assign bus_trn.in_valid = in_valid;  assign bus_trn.out_ready = out_ready;
  assign bus_trn.multiplicand = mcand; assign bus_trn.multiplier = mplier;
  assign bus_wrp.in_valid = in_valid;  assign bus_wrp.out_ready = out_ready;
  assign bus_wrp.multiplicand = mcand; assign bus_wrp.multiplier = mplier;

  fixed_point_multiplier #(.WIDTH(16), .FRAC(8), .ROUND(1), .SATURATE(1)) u_def (
    .clk(clk), .reset(reset), .bus(bus_def));
  fixed_point_multiplier #(.WIDTH(16), .FRAC(8), .ROUND(0), .SATURATE(1)) u_trn (
    .clk(clk), .reset(reset), .bus(bus_trn));
  fixed_point_multiplier #(.WIDTH(16), .FRAC(8), .ROUND(1), .SATURATE(0)) u_wrp (
    .clk(clk), .reset(reset), .bus(bus_wrp));

  always #5 clk = ~clk;

  // Reference: exact product, optional +0.5 LSB, floor shift, then clamp or wrap.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input bit rnd, input bit sat);
    longint      p;
    longint      r;
    logic        f;
    logic [15:0] v;
    p = longint'($signed(a)) * longint'($signed(b));
    if (rnd) p = p + 64'sd128;
    r = p >>> 8;
    f = (r > 64'sd32767) || (r < -64'sd32768);
    v = r[15:0];
    if (f && sat) v = (r < 0) ? 16'h8000 : 16'h7FFF;
    return {f, v};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input string tag, input logic [15:0] a, input logic [15:0] b);
    int guard;
    guard = 0;
    while (bus_def.in_ready !== 1'b1 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    chk({tag, "_in_ready"}, 32'(bus_def.in_ready), 32'h1);
    in_valid = 1'b1; mcand = a; mplier = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mcand  = 16'($urandom);
    mplier = 16'($urandom);
  endtask

  task automatic wait_out(input string tag);
    int lat;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (bus_def.out_valid !== 1'b1 && lat < 60);
    chk({tag, "_latency"}, 32'(lat), 32'd17);
    chk({tag, "_trn_valid"}, 32'(bus_trn.out_valid), 32'h1);
    chk({tag, "_wrp_valid"}, 32'(bus_wrp.out_valid), 32'h1);
  endtask

  task automatic check_res(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] er, input logic ef);
    logic [16:0] m;
    chk({tag, "_result"}, 32'(bus_def.o_result), 32'(er));
    chk({tag, "_flag"}, 32'(bus_def.overflow_flag), 32'(ef));
    m = model(a, b, 1'b0, 1'b1);
    chk({tag, "_trn"}, 32'({bus_trn.overflow_flag, bus_trn.o_result}), 32'(m));
    m = model(a, b, 1'b1, 1'b0);
    chk({tag, "_wrp"}, 32'({bus_wrp.overflow_flag, bus_wrp.o_result}), 32'(m));
  endtask

  task automatic consume(input string tag, input int stall);
    repeat (stall) begin @(posedge clk); #1; end
    chk({tag, "_held"}, 32'(bus_def.out_valid), 32'h1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drop"}, 32'(bus_def.out_valid), 32'h0);
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] m;
    logic        seen;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mcand = 16'h0000; mplier = 16'h0000;
    #6;
    chk("rst_out_valid", 32'(bus_def.out_valid), 32'h0);
    chk("rst_in_ready", 32'(bus_def.in_ready), 32'h1);
    chk("rst_result", 32'(bus_def.o_result), 32'h0);
    chk("rst_flag", 32'(bus_def.overflow_flag), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    start_op("mul_1p5x2", 16'h0180, 16'h0200);
    wait_out("mul_1p5x2");
    check_res("mul_1p5x2", 16'h0180, 16'h0200, 16'h0300, 1'b0);
    consume("mul_1p5x2", 0);

    start_op("half_lsb", 16'h0001, 16'h0080);
    wait_out("half_lsb");
    check_res("half_lsb", 16'h0001, 16'h0080, 16'h0001, 1'b0);
    chk("half_lsb_trunc_const", 32'(bus_trn.o_result), 32'h0000);
    consume("half_lsb", 1);

    start_op("neg_half", 16'hFF00, 16'h0080);
    wait_out("neg_half");
    check_res("neg_half", 16'hFF00, 16'h0080, 16'hFF80, 1'b0);
    consume("neg_half", 0);

    start_op("max_sq", 16'h7FFF, 16'h7FFF);
    wait_out("max_sq");
    check_res("max_sq", 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1);
    // 0x3FFF0001 + 0x80, shifted by 8, is 0x3FFF00: wrap keeps 0xFF00.
    chk("max_sq_wrap_const", 32'({bus_wrp.overflow_flag, bus_wrp.o_result}), 32'h1FF00);
    consume("max_sq", 2);

    start_op("min_x_max", 16'h8000, 16'h7FFF);
    wait_out("min_x_max");
    check_res("min_x_max", 16'h8000, 16'h7FFF, 16'h8000, 1'b1);
    consume("min_x_max", 0);

    start_op("min_sq", 16'h8000, 16'h8000);
    wait_out("min_sq");
    check_res("min_sq", 16'h8000, 16'h8000, 16'h7FFF, 1'b1);
    consume("min_sq", 0);

    start_op("rst_busy", 16'h7FFF, 16'h0200);
    repeat (6) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_busy_out_valid", 32'(bus_def.out_valid), 32'h0);
    chk("rst_busy_result", 32'(bus_def.o_result), 32'h0);
    chk("rst_busy_flag", 32'(bus_def.overflow_flag), 32'h0);
    chk("rst_busy_in_ready", 32'(bus_def.in_ready), 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (bus_def.out_valid !== 1'b0 || bus_def.in_ready !== 1'b1) seen = 1'b1;
    end
    chk("rst_busy_no_pulse", 32'(seen), 32'h0);
    start_op("after_rst", 16'h0100, 16'h0100);
    wait_out("after_rst");
    check_res("after_rst", 16'h0100, 16'h0100, 16'h0100, 1'b0);
    consume("after_rst", 0);

    start_op("stall", 16'h0300, 16'hFE00);
    wait_out("stall");
    for (int k = 0; k < 5; k++) begin
      in_valid = (k % 2 == 0); mcand = 16'h1234; mplier = 16'h4321;
      @(posedge clk); #1;
      chk("stall_valid", 32'(bus_def.out_valid), 32'h1);
      chk("stall_result", 32'(bus_def.o_result), 32'hFA00);
      chk("stall_flag", 32'(bus_def.overflow_flag), 32'h0);
      chk("stall_in_ready", 32'(bus_def.in_ready), 32'h0);
    end
    in_valid = 1'b0;
    consume("stall", 0);
    chk("idle_in_ready", 32'(bus_def.in_ready), 32'h1);
    chk("idle_keep_result", 32'(bus_def.o_result), 32'hFA00);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus_def.out_valid !== 1'b0) seen = 1'b1;
    end
    chk("stall_no_phantom", 32'(seen), 32'h0);

    for (int i = 0; i < 100; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 10 == 3) a = 16'h8000;
      if (i % 10 == 7) b = 16'h7FFF;
      if (i % 13 == 5) b = 16'h0000;
      start_op("stream", a, b);
      wait_out("stream");
      m = model(a, b, 1'b1, 1'b1);
      check_res("stream", a, b, m[15:0], m[16]);
      consume("stream", int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
